vscale_dmem_responder: RTL and testbench

- Data-memory responder (slave end) for the core's dmem port: accepts address-phase requests, sinks store data one cycle later, returns load data, and inserts wait states.
- Flags misaligned, out-of-range and illegal-size accesses via dmem_badmem_e.
- Backed by an internal word-organised SRAM array. Used as the dmem target in core-level simulation and small FPGA builds.

---
 rtl/vscale_dmem_responder.sv | 129 ++++++++++++
 tb/tb_vscale_dmem_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_dmem_responder.sv
// Data-memory slave for the vscale dmem port: a two-phase pipelined responder
// backed by a word-organised SRAM. It supports optional wait states and flags bad accesses.
module vscale_dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 4096,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata_delayed,
  output logic [31:0] dmem_rdata,
  output logic        dmem_wait,
  output logic        dmem_badmem_e
);

  localparam int          IW          = $clog2(DEPTH);
  localparam logic [2:0]  MEM_TYPE_SB = 3'd0;
  localparam logic [2:0]  MEM_TYPE_SH = 3'd1;
  localparam logic [2:0]  MEM_TYPE_SW = 3'd2;
  localparam logic [32:0] SPAN        = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          wen_q;
  logic          err_q;
  logic [2:0]    size_q;
  logic [1:0]    lane_q;
  logic [IW-1:0] index_q;

  logic [31:0]   mem [DEPTH];

  logic [31:0]   offset;
  logic          misaligned;
  logic          bad_size;
  logic          out_of_range;
  logic          accept;
  logic [3:0]    be;
  logic          commit;

  assign offset       = dmem_addr - BASE_ADDR;
  assign out_of_range = (dmem_addr < BASE_ADDR) || ({1'b0, offset} >= SPAN);
  assign accept       = dmem_en && (state != S_WAIT);
  assign commit       = (state == S_DATA) && wen_q && !err_q;

  // Address-phase size and alignment classification.
  always_comb begin
    misaligned = 1'b0;
    bad_size   = 1'b0;
    case (dmem_size)
      MEM_TYPE_SB: misaligned = 1'b0;
      MEM_TYPE_SH: misaligned = dmem_addr[0];
      MEM_TYPE_SW: misaligned = |dmem_addr[1:0];
      default:     bad_size   = 1'b1;
    endcase
  end

  // Byte-lane enables for the store in its final data-phase cycle.
  always_comb begin
    be = 4'b0000;
    case (size_q)
      MEM_TYPE_SB: be = 4'b0001 << lane_q;
      MEM_TYPE_SH: be = lane_q[1] ? 4'b1100 : 4'b0011;
      MEM_TYPE_SW: be = 4'b1111;
      default:     be = 4'b0000;
    endcase
  end

  // Protocol FSM: captures the address phase and sequences wait and data cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 3'd0;
      lane_q  <= 2'd0;
      index_q <= '0;
    end else if (accept) begin
      wen_q   <= dmem_wen;
      err_q   <= misaligned || bad_size || out_of_range;
      size_q  <= dmem_size;
      lane_q  <= dmem_addr[1:0];
      index_q <= offset[IW+1:2];
      if (WAIT_STATES > 0) begin
        state <= S_WAIT;
        cnt   <= 4'(WAIT_STATES);
      end else begin
        state <= S_DATA;
        cnt   <= 4'd0;
      end
    end else if (state == S_WAIT) begin
      if (cnt == 4'd1) begin
        state <= S_DATA;
        cnt   <= 4'd0;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end else begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end
  end

  // Store commit; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[index_q][8*i +: 8] <= dmem_wdata_delayed[8*i +: 8];
        end
      end
    end
  end

  assign dmem_wait     = (state == S_WAIT);
  assign dmem_badmem_e = (state == S_DATA) && err_q;
  assign dmem_rdata    = ((state == S_DATA) && !err_q) ? mem[index_q] : 32'd0;

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Bench for vscale_dmem_responder: three instances (different base/depth/wait states)
// checked every cycle against a transaction-level model, plus directed literal checks.
module tb_vscale_dmem_responder;

  localparam logic [2:0][31:0] BASE_T  = {32'h10, 32'h0, 32'h0};
  localparam logic [2:0][31:0] DEPTH_T = {32'd16, 32'd64, 32'd4096};
  localparam logic [2:0][3:0]  WS_T    = {4'd3, 4'd2, 4'd0};
  localparam logic [2:0] SB = 3'd0, SH = 3'd1, SW = 3'd2;

  logic        clk = 1'b0;
  logic [2:0]  rst_n = 3'b000;
  logic [2:0]  en = 3'b000;
  logic [2:0]  wen = 3'b000;
  logic [2:0]  size_a [3];
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic [2:0]  dwait;
  logic [2:0]  bad;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    vscale_dmem_responder #(
      .BASE_ADDR(BASE_T[g]),
      .DEPTH(int'(DEPTH_T[g])),
      .WAIT_STATES(int'(WS_T[g]))
    ) dut (
      .clk(clk),
      .reset(rst_n[g]),
      .dmem_en(en[g]),
      .dmem_wen(wen[g]),
      .dmem_size(size_a[g]),
      .dmem_addr(addr[g]),
      .dmem_wdata_delayed(wdata[g]),
      .dmem_rdata(rdata[g]),
      .dmem_wait(dwait[g]),
      .dmem_badmem_e(bad[g])
    );
  end

  // Model: byte-addressed memory plus one outstanding transaction per instance,
  // whose data cycle is scheduled WAIT_STATES+1 cycles after acceptance.
  logic [7:0]  mb [longint];
  bit          have [3];
  longint      dcyc [3];
  logic [31:0] taddr [3];
  logic [2:0]  tsize [3];
  bit          twen [3];
  bit          terr [3];
  longint      cyc = 0;

  function automatic longint key(input int k, input logic [31:0] a);
    return (longint'(k) << 32) | longint'(a);
  endfunction

  function automatic bit err_of(input int k, input logic [2:0] s, input logic [31:0] a);
    longint off;
    bit mis;
    bit oor;
    off = longint'(a) - longint'(BASE_T[k]);
    mis = (s == 3'd1 && a % 2 != 0) || (s == 3'd2 && a % 4 != 0);
    oor = (off < 0) || (off >= 4 * longint'(DEPTH_T[k]));
    return mis || oor || (s > 3'd2);
  endfunction

  task automatic commit_store(input int k);
    logic [31:0] wb;
    int lo;
    bit sel;
    wb = taddr[k] & ~32'd3;
    lo = int'(taddr[k] % 4);
    for (int j = 0; j < 4; j++) begin
      sel = (tsize[k] == 3'd0 && j == lo) || (tsize[k] == 3'd1 && j / 2 == lo / 2) || (tsize[k] == 3'd2);
      if (sel) mb[key(k, wb + 32'(j))] = wdata[k][8*j +: 8];
    end
  endtask

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!rst_n[k]) begin
        have[k] = 0;
      end else begin
        if (have[k] && dcyc[k] == cyc) begin
          if (twen[k] && !terr[k]) commit_store(k);
          have[k] = 0;
        end
        if (en[k] && !(have[k] && cyc < dcyc[k])) begin
          have[k]  = 1;
          dcyc[k]  = cyc + 1 + longint'(WS_T[k]);
          taddr[k] = addr[k];
          tsize[k] = size_a[k];
          twen[k]  = wen[k];
          terr[k]  = err_of(k, size_a[k], addr[k]);
        end
      end
    end
    cyc = cyc + 1;
  end

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      logic        ew, eb;
      logic [31:0] er, mask, wb;
      ew = 1'b0; eb = 1'b0; er = 32'd0; mask = 32'hFFFF_FFFF;
      if (rst_n[k]) begin
        if (have[k] && dcyc[k] == cyc) begin
          eb = terr[k];
          if (!terr[k]) begin
            wb = taddr[k] & ~32'd3;
            for (int j = 0; j < 4; j++) begin
              if (mb.exists(key(k, wb + 32'(j)))) er[8*j +: 8] = mb[key(k, wb + 32'(j))];
              else mask[8*j +: 8] = 8'h00;
            end
          end
        end else if (have[k]) begin
          ew = 1'b1;
        end
        checks++;
        if (dwait[k] !== ew || bad[k] !== eb || (rdata[k] & mask) !== (er & mask)) begin
          failures++;
          $display("FAIL model k%0d cyc%0d: wait/bad/rdata got %b/%b/%h expected %b/%b/%h",
                   k, cyc, dwait[k], bad[k], rdata[k], ew, eb, er & mask);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ap(input int k, input logic e, input logic w, input logic [2:0] s, input logic [31:0] a);
    en[k] = e; wen[k] = w; size_a[k] = s; addr[k] = a;
  endtask

  // Single non-pipelined access; returns positioned in its final data-phase cycle.
  task automatic run_txn(input int k, input logic w, input logic [2:0] s, input logic [31:0] a, input logic [31:0] wd);
    int n;
    ap(k, 1'b1, w, s, a);
    step();
    ap(k, 1'b0, 1'b0, 3'd0, 32'd0);
    n = 0;
    while (dwait[k] && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("txn_timeout", 32'(n), 32'd0);
    wdata[k] = wd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r;
    for (int k = 0; k < 3; k++) begin
      size_a[k] = 3'd0; addr[k] = 32'd0; wdata[k] = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_wait", 32'(dwait[k]), 32'd0);
      chk("reset_bad", 32'(bad[k]), 32'd0);
      chk("reset_rdata", rdata[k], 32'd0);
    end
    step();
    rst_n = 3'b111;

    // Instance 0, no wait states.
    ap(0, 1, 1, SW, 32'h40); step();
    wdata[0] = 32'hDEADBEEF; ap(0, 1, 0, SW, 32'h40); step();
    ap(0, 0, 0, SB, 32'h0);
    @(negedge clk); chk("lw_deadbeef", rdata[0], 32'hDEADBEEF); chk("lw_wait", 32'(dwait[0]), 32'd0);
    step();
    ap(0, 1, 1, SW, 32'h80); step();
    wdata[0] = 32'h11223344; ap(0, 1, 1, SB, 32'h82); step();
    wdata[0] = 32'hAAAAAAAA; ap(0, 1, 0, SW, 32'h80); step();
    ap(0, 0, 0, SB, 32'h0);
    @(negedge clk); chk("byte_lane", rdata[0], 32'h11AA3344);
    step();
    ap(0, 1, 1, SH, 32'h81); step();
    wdata[0] = 32'hFFFFFFFF; ap(0, 1, 0, SW, 32'h80);
    @(negedge clk); chk("sh_misaligned_bad", 32'(bad[0]), 32'd1);
    step();
    ap(0, 0, 0, SB, 32'h0);
    @(negedge clk); chk("sh_misaligned_nowrite", rdata[0], 32'h11AA3344);
    step();
    ap(0, 1, 0, SW, 32'h4000); step();
    ap(0, 0, 0, SB, 32'h0);
    @(negedge clk); chk("oor_bad", 32'(bad[0]), 32'd1); chk("oor_rdata", rdata[0], 32'd0);
    step();
    ap(0, 1, 0, 3'd3, 32'h40); step();
    ap(0, 0, 0, SB, 32'h0);
    @(negedge clk); chk("size3_bad", 32'(bad[0]), 32'd1);
    step();
    ap(0, 1, 1, SW, 32'h10); step();
    wdata[0] = 32'd5; ap(0, 1, 0, SW, 32'h10); step();
    ap(0, 1, 1, SW, 32'h14);
    @(negedge clk); chk("b2b_ld5", rdata[0], 32'd5); chk("b2b_wait", 32'(dwait[0]), 32'd0);
    step();
    wdata[0] = 32'd7; ap(0, 1, 0, SW, 32'h14); step();
    ap(0, 0, 0, SB, 32'h0);
    @(negedge clk); chk("b2b_ld7", rdata[0], 32'd7);
    step();

    // Instance 1, two wait states; an en pulse during the wait must be ignored.
    ap(1, 1, 1, SW, 32'h40); step();
    ap(1, 0, 0, SB, 32'h0);
    @(negedge clk); chk("ws_st_w1", 32'(dwait[1]), 32'd1); step();
    @(negedge clk); chk("ws_st_w2", 32'(dwait[1]), 32'd1); step();
    wdata[1] = 32'hCAFEF00D; ap(1, 1, 0, SW, 32'h40);
    @(negedge clk); chk("ws_st_data", 32'(dwait[1]), 32'd0); step();
    ap(1, 1, 1, SW, 32'h44); wdata[1] = 32'h12345678;
    @(negedge clk); chk("ws_ld_w1", 32'(dwait[1]), 32'd1); step();
    ap(1, 0, 0, SB, 32'h0);
    @(negedge clk); chk("ws_ld_w2", 32'(dwait[1]), 32'd1); step();
    @(negedge clk); chk("ws_ld_data_wait", 32'(dwait[1]), 32'd0); chk("ws_ld_rdata", rdata[1], 32'hCAFEF00D); step();
    @(negedge clk); chk("ws_pulse_ignored", 32'(dwait[1]), 32'd0); step();

    // Instance 2, three wait states; reset dropped mid-store.
    run_txn(2, 1, SW, 32'h20, 32'h600DD00D); step();
    ap(2, 1, 1, SW, 32'h20); step();
    ap(2, 0, 0, SB, 32'h0); wdata[2] = 32'h0BAD0BAD; step();
    chk("rst_pre_wait", 32'(dwait[2]), 32'd1);
    rst_n[2] = 1'b0;
    #1;
    chk("rst_wait", 32'(dwait[2]), 32'd0); chk("rst_bad", 32'(bad[2]), 32'd0); chk("rst_rdata", rdata[2], 32'd0);
    step(); step();
    rst_n[2] = 1'b1;
    run_txn(2, 0, SW, 32'h20, 32'd0);
    @(negedge clk); chk("rst_old_value", rdata[2], 32'h600DD00D);
    step();

    // Randomised traffic on all instances; inputs change freely, even during waits.
    repeat (2500) begin
      for (int k = 0; k < 3; k++) begin
        en[k]  = ($urandom % 10) < 6;
        wen[k] = 1'($urandom % 2);
        r = int'($urandom % 16);
        size_a[k] = (r < 5) ? SB : (r < 10) ? SH : (r < 15) ? SW : 3'($urandom_range(3, 7));
        r = int'($urandom % 20);
        case (r)
          0:       addr[k] = BASE_T[k] + (DEPTH_T[k] << 2);
          1:       addr[k] = BASE_T[k] + (DEPTH_T[k] << 2) - 32'd4 + 32'($urandom % 4);
          2:       addr[k] = (BASE_T[k] == 32'd0) ? 32'hFFFF_FFFC : BASE_T[k] - 32'd4;
          default: addr[k] = BASE_T[k] + 32'($urandom_range(0, 63));
        endcase
        wdata[k] = $urandom;
      end
      step();
    end
    for (int k = 0; k < 3; k++) ap(k, 0, 0, SB, 32'h0);
    repeat (8) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
